// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives pc to instruction memory and hands fetched
// words to decode through a one-entry valid/ready output slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd100
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instruction_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {INIT, FETCH, HALT, FAULT} state_t;

    state_t state;
    logic   slot_free;

    assign slot_free    = !out_valid || out_ready;
    assign out_pc_plus4 = out_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= INIT;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else if (redirect_valid && state != FAULT) begin
            // Redirect beats fetch and stall; the slot is always flushed.
            out_valid <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                fault <= 1'b1;
                state <= FAULT;
            end else begin
                pc     <= redirect_target;
                halted <= 1'b0;
                state  <= FETCH;
            end
        end else begin
            case (state)
                INIT: state <= FETCH;
                FETCH: begin
                    if (pc >= PC_LIMIT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                        if (out_ready)
                            out_valid <= 1'b0;
                    end else if (slot_free) begin
                        out_instr <= instruction_code;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + 32'd4;
                    end
                end
                HALT: begin
                    // The word captured before halting still drains to decode.
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                FAULT: out_valid <= 1'b0;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected fetch addresses
// checked on every output handshake, plus directed checks of control behaviour.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instruction_code;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic        fault;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_LIMIT(32'd100)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .instruction_code (instruction_code),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .out_pc_plus4     (out_pc_plus4),
        .halted           (halted),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb instruction_code = mem_word(pc);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted word must match the next expected address.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_out_pc", out_pc, e);
                check("sb_out_instr", out_instr, mem_word(e));
                check("sb_out_pc_plus4", out_pc_plus4, e + 32'd4);
            end
        end
    end

    initial begin
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b1;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        // Sequential fetch with latency check and a three-cycle stall on word 4.
        for (int unsigned a = 0; a <= 32'hC; a += 4) exp_q.push_back(a);
        reset = 1'b1;
        tick();
        check("init_no_capture", {31'd0, out_valid}, 32'd0);
        tick();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_out_pc", out_pc, 32'h0);
        tick();
        check("second_out_pc", out_pc, 32'h4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 32'h8);
            check("stall_instr", out_instr, mem_word(32'h4));
            check("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("resume_out_pc", out_pc, 32'h8);
        tick();
        tick();
        check("pre_redirect_out_pc", out_pc, 32'h10);

        // Redirect flushes the held word at 0x10.
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h48;
        check("sb_drain1", exp_q.size(), 32'd0);
        tick();
        check("redir_valid", {31'd0, out_valid}, 32'd0);
        check("redir_pc", pc, 32'h48);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int unsigned a = 32'h48; a <= 32'd96; a += 4) exp_q.push_back(a);
        tick();
        check("redir_out_pc", out_pc, 32'h48);
        check("redir_out_valid", {31'd0, out_valid}, 32'd1);

        for (int i = 0; i < 40 && halted !== 1'b1; i++) tick();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, 32'd100);
        check("halt_drained", {31'd0, out_valid}, 32'd0);
        check("sb_drain2", exp_q.size(), 32'd0);
        tick();
        tick();
        check("halt_hold_pc", pc, 32'd100);
        check("halt_hold_flag", {31'd0, halted}, 32'd1);

        // Aligned redirect leaves HALT.
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        tick();
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        check("unhalt_pc", pc, 32'h20);
        redirect_valid = 1'b0;
        tick();
        check("unhalt_out_pc", out_pc, 32'h20);
        tick();
        tick();
        check("unhalt_third_out_pc", out_pc, 32'h28);
        out_ready = 1'b0;
        check("sb_drain3", exp_q.size(), 32'd0);

        // Misaligned redirect faults; later redirects are ignored.
        redirect_valid  = 1'b1;
        redirect_target = 32'h4A;
        tick();
        check("fault_flag", {31'd0, fault}, 32'd1);
        check("fault_valid", {31'd0, out_valid}, 32'd0);
        check("fault_pc", pc, 32'h2C);
        redirect_target = 32'h0;
        out_ready       = 1'b1;
        tick();
        tick();
        check("fault_ignore_pc", pc, 32'h2C);
        check("fault_sticky", {31'd0, fault}, 32'd1);
        check("fault_no_valid", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b0;
        reset          = 1'b0;
        tick();
        check("fault_clr", {31'd0, fault}, 32'd0);
        check("fault_rst_pc", pc, 32'h0);
        check("fault_rst_halted", {31'd0, halted}, 32'd0);

        // Reset with a same-cycle redirect and an occupied slot.
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        check("occ_valid", {31'd0, out_valid}, 32'd1);
        check("occ_out_pc", out_pc, 32'h0);
        reset           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        check("rr_pc", pc, 32'h0);
        check("rr_valid", {31'd0, out_valid}, 32'd0);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        check("rr_init_valid", {31'd0, out_valid}, 32'd0);
        check("rr_init_pc", pc, 32'h0);
        tick();
        check("rr_first_valid", {31'd0, out_valid}, 32'd1);
        check("rr_first_out_pc", out_pc, 32'h0);
        @(negedge clk);
        #1;
        check("sb_drain4", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: the PC loaded on reset.
REQ-002 The block SHALL have parameter PC_LIMIT, default 32'd100: the first byte address that is not fetched.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; the ports are listed below.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous active-low reset; reset==0 at a rising edge resets the block.
REQ-006 pc  output  32  current fetch address, driven to the instruction memory.
REQ-007 instruction_code  input  32  instruction word at pc, read combinationally in the same cycle.
REQ-008 redirect_valid  input  1  a branch or jump was taken; this cycle only.
REQ-009 redirect_target  input  32  new fetch address; sampled only when redirect_valid==1.
REQ-010 out_valid  output  1  out_instr, out_pc and out_pc_plus4 hold a fetched instruction.
REQ-011 out_ready  input  1  the decode stage accepts the output this cycle.
REQ-012 out_instr  output  32  fetched instruction word.
REQ-013 out_pc  output  32  address the word was fetched from.
REQ-014 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-015 halted  output  1  fetch stopped because pc >= PC_LIMIT.
REQ-016 fault  output  1  sticky: a misaligned redirect target was received.

Function
REQ-017 The FSM SHALL have four states: INIT, FETCH, HALT and FAULT.
REQ-018 INIT SHALL last exactly one cycle, with no capture, and then go to FETCH.
REQ-019 The output slot SHALL be free in a cycle when out_valid==0 or out_ready==1.
REQ-020 In FETCH with the slot free, no redirect and pc < PC_LIMIT, the block SHALL load the slot as follows on the next edge:
 - out_instr <= instruction_code
 - out_pc <= pc
 - out_valid <= 1
 - pc <= pc + 4
REQ-021 In FETCH with the slot occupied and out_ready==0 (stall), pc and all out_* SHALL hold unchanged.
REQ-022 Fetch-to-output latency SHALL be one cycle; with out_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-023 A redirect SHALL take priority over fetch and stall; a valid redirect in any state except FAULT causes, on the next edge:
 - pc <= redirect_target
 - out_valid <= 0, so a held or in-flight word is flushed
 - state <= FETCH
REQ-024 A redirect with redirect_target[1:0] != 0 SHALL leave pc unchanged, clear out_valid, set fault=1 and enter FAULT.
REQ-025 FAULT SHALL be left only by reset; while in FAULT, redirects are ignored and out_valid stays 0.
REQ-026 In FETCH with pc >= PC_LIMIT and no redirect, the block SHALL enter HALT with halted=1 and make no further captures.
REQ-027 Entering HALT SHALL keep the current slot; it drains normally on out_ready.
REQ-028 In HALT, pc SHALL hold; halted SHALL clear when an aligned redirect moves the block back to FETCH.
REQ-029 pc + 4 SHALL wrap modulo 2^32 with no flag.
REQ-030 out_pc_plus4 SHALL be derived combinationally from out_pc.

Reset
REQ-031 Reset SHALL set:
 - pc = RESET_PC
 - out_valid = 0, out_instr = 0, out_pc = 0
 - halted = 0, fault = 0
 - state = INIT
REQ-032 Reset SHALL override every other input, including a same-cycle redirect.
REQ-033 Reset asserted mid-stall SHALL discard the held word.

Verification
REQ-034 Release reset, out_ready=1, memory words A,B,C at 0,4,8 -> out_valid first high 2 edges after release; then out_pc = 0,4,8 on consecutive cycles; out_instr = A,B,C.
REQ-035 Stall: out_ready=0 for 3 cycles while out_pc=4 -> pc stays 8, out_instr stays B, out_valid stays 1; the word at 8 appears 1 cycle after out_ready returns to 1.
REQ-036 redirect_valid=1 with target 0x48 while out_pc=0x10 is valid -> next cycle out_valid=0 and pc=0x48; the cycle after, out_pc=0x48.
REQ-037 Run with PC_LIMIT=100 -> last out_pc=96 and halted=1; a later redirect to 0x20 -> halted=0 and fetch resumes at 0x20.
REQ-038 Redirect target 0x4A -> fault=1 and out_valid=0; a later redirect to 0x0 is ignored; reset clears fault and pc=0.
REQ-039 Reset asserted together with a redirect to 0x40, slot occupied -> pc=RESET_PC, out_valid=0, state INIT.
